seq_checker: RTL and testbench
==============================

# seq_checker

Receive-side companion to the 8-bit sequence generator: it consumes the generator's `out` stream, acquires the running sequence, and then verifies every subsequent sample against the expected value. It reports lock status, per-sample error pulses and a saturating error count. It sits directly on the generator's output bus in the bench and in the integration top.

## Interface
Parameters:
- `WIDTH`, 8: sample width; all sequence arithmetic is modulo 2^WIDTH.
- `STEP`, 1: expected increment between consecutive valid samples, range 0..2^WIDTH-1.
- `LOCK_CNT`, 4: consecutive in-sequence samples needed to declare lock, including the seed sample; must be ≥2.
- `LOSS_CNT`, 3: consecutive mismatches in LOCKED that drop lock; must be ≥1.
- `CNT_W`, 16: error counter width.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_data` is a sample this cycle.
- `in_data`  in  WIDTH  sample from the generator.
- `clr`  in  1  synchronous clear of `err_cnt` only.
- `locked`  out  1  high while in LOCKED.
- `err`  out  1  one-cycle pulse per mismatching sample in LOCKED.
- `err_cnt`  out  CNT_W  saturating count of `err` pulses.
- `exp_data`  out  WIDTH  next expected sample.
- `state`  out  2  current FSM state encoding, for debug.

## Operation
- FSM states: SEARCH=0, VERIFY=1, LOCKED=2. Encoding 3 is unused and recovers to SEARCH.
- `in_valid`=0: no state, counter or `exp_data` change; `err`=0.
- SEARCH, valid sample d: set `exp_data`=d+STEP, set streak=1, go to VERIFY. No `err`.
- VERIFY, valid d == `exp_data`: streak+1, `exp_data`+=STEP. When streak reaches LOCK_CNT, go to LOCKED and clear the miss counter.
- VERIFY, valid d != `exp_data`: reseed with `exp_data`=d+STEP and streak=1. Stay in VERIFY. No `err`.
- LOCKED, match: `exp_data`+=STEP, miss=0.
- LOCKED, mismatch: `err`=1, `err_cnt`+1 (saturates at 2^CNT_W-1), miss+1. `exp_data`+=STEP, so the expected sequence freewheels and does not reseed. When miss reaches LOSS_CNT, go to SEARCH and drop `locked`.
- Wrap-around: 2^WIDTH-1 + STEP wraps modulo 2^WIDTH and counts as a match. Example: 255→0 with STEP=1.
- `clr` zeroes `err_cnt` and takes priority over a same-cycle increment. `clr` leaves the FSM, `exp_data` and `err` unaffected.
- `rst` takes priority over everything. On the next edge: state=SEARCH, `locked`=0, `err`=0, `err_cnt`=0, `exp_data`=0, streak=0, miss=0. This applies equally mid-VERIFY and mid-LOCKED.

## Timing
- All outputs are registered. Reset value of every output is 0; `state` resets to SEARCH.
- Latency is one cycle: the response to a sample presented at edge k is visible after edge k.
- Lock timing: with the seed accepted at edge k and continuous valid matches, `locked` is high after edge k+LOCK_CNT-1.
- `err` is high for exactly the cycle after each mismatching LOCKED sample. Back-to-back mismatches give back-to-back `err` pulses.
- Lock drop: `locked` falls and `err` pulses in the same cycle, after the LOSS_CNT-th consecutive mismatch. The next valid sample then seeds SEARCH.
- No back-pressure: every valid sample is consumed.

## Structure
- Package `seq_chk_pkg` holds:
  - state encodings SEARCH, VERIFY and LOCKED;
  - the state width constant (2).
- Sub-module `sat_counter`, parameterised by width, with inputs `inc` and `clr` (clr priority) and a saturating output. It implements `err_cnt`.
- The streak and miss counters are sized to $clog2(LOCK_CNT+1) and $clog2(LOSS_CNT+1) bits respectively.

## Test plan
- Acquire: after reset, stream 0,1,2,3,4 with valid every cycle → `locked` rises after the sample 3 edge; `err_cnt`=0; `exp_data`=5 after sample 4.
- Wrap: while locked, stream 253,254,255,0,1 → no `err`; `locked` stays high; `exp_data`=2 at end.
- Single glitch: locked and expecting 10, send 0x55 then 11,12 → one `err` pulse; `err_cnt`=1; lock held; `exp_data`=13.
- Loss and relock: send three mismatches → three `err` pulses, `err_cnt`=3, `locked` falls with the third. Then send 40,41,42,43 → relock after 43.
- Gaps and clear: toggle `in_valid` low between samples → no extra state changes. Assert `clr` in the same cycle as a mismatch → `err_cnt`=0, `err` still pulses. Saturation with CNT_W=2 → holds at 3.
- Reset mid-operation: assert `rst` while in LOCKED with `err_cnt`=5 → next cycle all outputs are 0 and `state`=SEARCH. The first valid sample after that reseeds.

Source files
------------

// File: rtl/seq_chk_pkg.sv
// Shared definitions for the sequence checker: FSM state encodings and width.
package seq_chk_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_checker.sv
// Receive-side checker: acquires a stepping sample sequence, then flags and counts
// every sample that departs from it while locked.
module seq_checker
    import seq_chk_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               clr,
    output logic               locked,
    output logic               err,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [WIDTH-1:0]   exp_data,
    output logic [STATE_W-1:0] state
);

    localparam int SW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);
    localparam logic [WIDTH-1:0] STEP_V    = WIDTH'(STEP);
    localparam logic [SW-1:0]    LOCK_LAST = SW'(LOCK_CNT - 1);
    localparam logic [MW-1:0]    LOSS_LAST = MW'(LOSS_CNT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [SW-1:0]    streak_q, streak_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic             err_q, err_d;
    logic             locked_q;
    logic             match;

    assign match = (in_data == exp_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Transition on the sample that completes the streak or the miss run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH:  if (in_valid) state_d = VERIFY;
            VERIFY:  if (in_valid && match && (streak_q == LOCK_LAST)) state_d = LOCKED;
            LOCKED:  if (in_valid && !match && (miss_q == LOSS_LAST)) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        exp_d    = exp_q;
        streak_d = streak_q;
        miss_d   = miss_q;
        err_d    = 1'b0;
        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    exp_d    = in_data + STEP_V;
                    streak_d = SW'(1);
                end
                VERIFY: begin
                    if (match) begin
                        exp_d    = exp_q + STEP_V;
                        streak_d = streak_q + 1'b1;
                        if (streak_q == LOCK_LAST) miss_d = '0;
                    end else begin
                        exp_d    = in_data + STEP_V;
                        streak_d = SW'(1);
                    end
                end
                LOCKED: begin
                    // Freewheel: expected value advances even on a mismatch.
                    exp_d = exp_q + STEP_V;
                    if (match) begin
                        miss_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q    <= '0;
            streak_q <= '0;
            miss_q   <= '0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            streak_q <= streak_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
            locked_q <= (state_d == LOCKED);
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_d),
        .clr (clr),
        .cnt (err_cnt)
    );

    assign locked   = locked_q;
    assign err      = err_q;
    assign exp_data = exp_q;
    assign state    = state_q;

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: vector table plus hand-written sequences, checked through a scoreboard queue.
module tb_seq_checker;

    logic       clk = 1'b0;
    logic       rst, in_valid, clr;
    logic [7:0] in_data;

    logic        locked, err, locked2, err2;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt2;
    logic [7:0]  exp_data, exp_data2;
    logic [1:0]  state, state2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r, v, c;
        logic [7:0] d;
        logic       l, e;
        int         cnt, cnt2;
        logic [7:0] x;
        logic [1:0] s;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    seq_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .locked(locked), .err(err), .err_cnt(err_cnt), .exp_data(exp_data), .state(state)
    );

    seq_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .locked(locked2), .err(err2), .err_cnt(err_cnt2), .exp_data(exp_data2), .state(state2)
    );

    function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic c, logic l, logic e,
                                int cnt, int cnt2, logic [7:0] x, logic [1:0] s);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.c = c; t.l = l; t.e = e;
        t.cnt = cnt; t.cnt2 = cnt2; t.x = x; t.s = s;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s step %0d got %0h want %0h", nm, idx, act, want);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        vec_t e;
        @(negedge clk);
        rst = t.r; in_valid = t.v; in_data = t.d; clr = t.c;
        sb.push_back(t);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("locked",   idx, {31'd0, locked},   {31'd0, e.l});
        chk("err",      idx, {31'd0, err},      {31'd0, e.e});
        chk("err_cnt",  idx, {16'd0, err_cnt},  e.cnt);
        chk("err_cnt2", idx, {30'd0, err_cnt2}, e.cnt2);
        chk("exp_data", idx, {24'd0, exp_data}, {24'd0, e.x});
        chk("state",    idx, {30'd0, state},    {30'd0, e.s});
    endtask

    initial begin
        logic [7:0] m;
        int         c;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clr = 1'b0;

        //           r  v  d     c  l  e  cnt c2 x    s
        tbl.push_back(mk(1, 0, 8'd0,   0, 0, 0, 0, 0, 8'd0,   0)); // reset
        tbl.push_back(mk(0, 1, 8'd0,   0, 0, 0, 0, 0, 8'd1,   1)); // seed
        tbl.push_back(mk(0, 1, 8'd1,   0, 0, 0, 0, 0, 8'd2,   1));
        tbl.push_back(mk(0, 1, 8'd2,   0, 0, 0, 0, 0, 8'd3,   1));
        tbl.push_back(mk(0, 1, 8'd3,   0, 1, 0, 0, 0, 8'd4,   2)); // lock
        tbl.push_back(mk(0, 1, 8'd4,   0, 1, 0, 0, 0, 8'd5,   2));
        tbl.push_back(mk(0, 0, 8'd99,  0, 1, 0, 0, 0, 8'd5,   2)); // gap
        tbl.push_back(mk(1, 0, 8'd0,   0, 0, 0, 0, 0, 8'd0,   0));
        tbl.push_back(mk(0, 1, 8'd250, 0, 0, 0, 0, 0, 8'd251, 1));
        tbl.push_back(mk(0, 1, 8'd251, 0, 0, 0, 0, 0, 8'd252, 1));
        tbl.push_back(mk(0, 1, 8'd252, 0, 0, 0, 0, 0, 8'd253, 1));
        tbl.push_back(mk(0, 1, 8'd253, 0, 1, 0, 0, 0, 8'd254, 2));
        tbl.push_back(mk(0, 1, 8'd254, 0, 1, 0, 0, 0, 8'd255, 2));
        tbl.push_back(mk(0, 1, 8'd255, 0, 1, 0, 0, 0, 8'd0,   2)); // wrap
        tbl.push_back(mk(0, 1, 8'd0,   0, 1, 0, 0, 0, 8'd1,   2));
        tbl.push_back(mk(0, 1, 8'd1,   0, 1, 0, 0, 0, 8'd2,   2));
        tbl.push_back(mk(0, 1, 8'h55,  0, 1, 1, 1, 1, 8'd3,   2)); // glitch
        tbl.push_back(mk(0, 1, 8'd3,   0, 1, 0, 1, 1, 8'd4,   2));
        tbl.push_back(mk(0, 1, 8'd4,   0, 1, 0, 1, 1, 8'd5,   2));
        tbl.push_back(mk(0, 1, 8'h77,  1, 1, 1, 0, 0, 8'd6,   2)); // clr beats inc
        tbl.push_back(mk(0, 0, 8'd6,   0, 1, 0, 0, 0, 8'd6,   2));
        tbl.push_back(mk(0, 1, 8'd6,   0, 1, 0, 0, 0, 8'd7,   2));
        tbl.push_back(mk(0, 1, 8'd0,   0, 1, 1, 1, 1, 8'd8,   2)); // loss run
        tbl.push_back(mk(0, 1, 8'd0,   0, 1, 1, 2, 2, 8'd9,   2));
        tbl.push_back(mk(0, 1, 8'd0,   0, 0, 1, 3, 3, 8'd10,  0));
        tbl.push_back(mk(0, 1, 8'd40,  0, 0, 0, 3, 3, 8'd41,  1)); // relock
        tbl.push_back(mk(0, 1, 8'd41,  0, 0, 0, 3, 3, 8'd42,  1));
        tbl.push_back(mk(0, 1, 8'd42,  0, 0, 0, 3, 3, 8'd43,  1));
        tbl.push_back(mk(0, 1, 8'd43,  0, 1, 0, 3, 3, 8'd44,  2));
        tbl.push_back(mk(0, 1, 8'd0,   0, 1, 1, 4, 3, 8'd45,  2)); // saturates at 3
        tbl.push_back(mk(0, 1, 8'd45,  0, 1, 0, 4, 3, 8'd46,  2));
        tbl.push_back(mk(0, 1, 8'd0,   0, 1, 1, 5, 3, 8'd47,  2));
        tbl.push_back(mk(1, 1, 8'd47,  1, 0, 0, 0, 0, 8'd0,   0)); // reset mid-LOCKED
        tbl.push_back(mk(0, 1, 8'd100, 0, 0, 0, 0, 0, 8'd101, 1));
        tbl.push_back(mk(0, 1, 8'd7,   0, 0, 0, 0, 0, 8'd8,   1)); // reseed in VERIFY
        tbl.push_back(mk(0, 1, 8'd8,   0, 0, 0, 0, 0, 8'd9,   1));
        tbl.push_back(mk(0, 1, 8'd9,   0, 0, 0, 0, 0, 8'd10,  1));
        tbl.push_back(mk(0, 0, 8'd10,  0, 0, 0, 0, 0, 8'd10,  1));
        tbl.push_back(mk(0, 1, 8'd10,  0, 1, 0, 0, 0, 8'd11,  2));

        foreach (tbl[i]) apply(tbl[i], i);

        // Locked stream with random gaps; idle cycles carry junk data.
        m = 8'd11;
        for (int i = 0; i < 16; i++) begin
            logic       v;
            logic [7:0] d;
            v = 1'($urandom_range(0, 1));
            d = v ? m : 8'($urandom);
            if (v) m = m + 8'd1;
            apply(mk(0, v, d, 0, 1, 0, 0, 0, m, 2), 100 + i);
        end

        // A match between mismatches restarts the miss run; the third in a row drops lock.
        c = 0;
        for (int i = 0; i < 6; i++) begin
            logic       hit, lk;
            logic [7:0] d;
            hit = (i == 2);
            d   = hit ? m : (m ^ 8'h80);
            if (!hit) c++;
            lk  = (i != 5);
            m   = m + 8'd1;
            apply(mk(0, 1, d, 0, lk, !hit, c, (c > 3) ? 3 : c, m, lk ? 2'd2 : 2'd0), 200 + i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
